// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi
//   Pipelined DVI TMDS 8b/10b encoder for NUM_CH independent colour channels
//   sharing one data-enable. Latency is two pixel clocks with no stalls.
//   Each channel keeps its own running-disparity counter. During blanking,
//   each channel emits the DVI control token selected by its own 2-bit ctrl.
//
// Ports
//   clk    in   pixel clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   de     in   1 = active video, 0 = blanking/control
//   data   in   DW*NUM_CH  pixel components, channel k at data[8k+7:8k]
//   ctrl   in   2*NUM_CH   {c1,c0} per channel, channel k at ctrl[2k+1:2k]
//   tmds   out  10*NUM_CH  10-bit symbols, channel k at tmds[10k+9:10k]
//
// Pipeline
//   stage 1: transition-minimised q_m, with de/ctrl delayed alongside
//   stage 2: DC-balanced symbol or control token, plus the disparity update

module tmds_encoder_multi #(
  parameter int NUM_CH = 3,
  parameter int DW     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   de,
  input  logic [DW*NUM_CH-1:0]   data,
  input  logic [2*NUM_CH-1:0]    ctrl,
  output logic [10*NUM_CH-1:0]   tmds
);

  if (DW != 8) begin : g_dw_check
    $error("tmds_encoder_multi: DW must be 8");
  end

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Choose whichever chain (XOR or XNOR) gives fewer transitions.
  // q_m[8] records the choice so the receiver can undo it.
  function automatic logic [8:0] stage1_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // The result packs {cnt_next[4:0], symbol[9:0]}. The arithmetic is 5-bit
  // two's complement. The encoding keeps |cnt| <= 10, so wrap-around never
  // happens.
  function automatic logic [14:0] stage2(input logic [8:0]        qm,
                                         input logic signed [4:0] cnt);
    logic [3:0]        n1;
    logic signed [5:0] diff6;
    logic signed [4:0] diff;     // N1 - N0 = 2*N1 - 8
    logic [9:0]        sym;
    logic signed [4:0] c;
    n1    = popcount8(qm[7:0]);
    diff6 = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    diff  = diff6[4:0];
    if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      c   = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
      // Running disparity and word disparity have the same sign: invert.
      sym = {1'b1, qm[8], ~qm[7:0]};
      c   = cnt + $signed({3'b000, qm[8], 1'b0}) - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      c   = cnt - $signed({3'b000, ~qm[8], 1'b0}) + diff;
    end
    return {c, sym};
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return TOKEN_00;
      2'b01:   return TOKEN_01;
      2'b10:   return TOKEN_10;
      default: return TOKEN_11;
    endcase
  endfunction

  // Pipeline state
  logic                   de_s1;
  logic [2*NUM_CH-1:0]    ctrl_s1;
  logic [9*NUM_CH-1:0]    qm_s1;
  logic [10*NUM_CH-1:0]   tmds_reg;
  logic [5*NUM_CH-1:0]    cnt_reg;

  logic [9*NUM_CH-1:0]    qm_next;
  logic [15*NUM_CH-1:0]   s2_res;
  logic [10*NUM_CH-1:0]   tmds_next;
  logic [5*NUM_CH-1:0]    cnt_next;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign qm_next[9*gi +: 9]  = stage1_qm(data[DW*gi +: 8]);
    assign s2_res[15*gi +: 15] = stage2(qm_s1[9*gi +: 9], cnt_reg[5*gi +: 5]);
    // Stage 2 selects on the delayed de, so garbage in q_m during blanking
    // never reaches the symbol or the disparity counter.
    assign tmds_next[10*gi +: 10] = de_s1 ? s2_res[15*gi +: 10]
                                          : token(ctrl_s1[2*gi +: 2]);
    assign cnt_next[5*gi +: 5]    = de_s1 ? s2_res[15*gi + 10 +: 5] : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1    <= 1'b0;
      ctrl_s1  <= '0;
      qm_s1    <= '0;
      tmds_reg <= {NUM_CH{TOKEN_00}};
      cnt_reg  <= '0;
    end else begin
      de_s1    <= de;
      ctrl_s1  <= ctrl;
      qm_s1    <= qm_next;
      tmds_reg <= tmds_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign tmds = tmds_reg;

endmodule
